alu_issue_arbiter: RTL and testbench

ALU_ISSUE_ARBITER -- requirements
Module: alu_issue_arbiter

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 40 ++++
 rtl/alu_issue_arbiter.sv | 150 +++++++++++++++
 tb/tb_alu_issue_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath, rename-tag and ROB widths, ALU opcodes.
package cpu_pkg;

  localparam int REG_SIZE      = 32;
  localparam int NUM_TAGS      = 64;
  localparam int NUM_TAGS_LOG2 = $clog2(NUM_TAGS);
  localparam int ROB_SIZE      = 64;
  localparam int ROB_SIZE_LOG2 = $clog2(ROB_SIZE);
  localparam int ALU_OP_W      = 4;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: scans requesters starting at the priority pointer
// and returns a one-hot grant, its index and the pointer that follows it.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               i_en,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [PTR_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic               o_any,
  output logic [PTR_W-1:0]   o_idx,
  output logic [PTR_W-1:0]   o_next_ptr
);

  // First active requester at or after the pointer wins (wrapping).
  always_comb begin
    int idx;
    logic [PTR_W-1:0] idx_l;
    idx        = 0;
    idx_l      = '0;
    o_gnt      = '0;
    o_any      = 1'b0;
    o_idx      = '0;
    o_next_ptr = i_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx   = (int'(i_ptr) + i) % NUM_REQ;
      idx_l = PTR_W'(idx);
      if (i_en && !o_any && i_req[idx_l]) begin
        o_gnt[idx_l] = 1'b1;
        o_any        = 1'b1;
        o_idx        = idx_l;
        o_next_ptr   = PTR_W'((idx + 1) % NUM_REQ);
      end else begin
        o_gnt[idx_l] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_issue_arbiter.sv
// ALU issue arbiter: picks one ready reservation station per cycle,
// registers the op into the issue stage that drives the external ALU,
// then captures the ALU result into a CDB-facing result stage.
module alu_issue_arbiter import cpu_pkg::*; #(
  parameter int NUM_REQ       = 4,
  parameter int REG_SIZE      = cpu_pkg::REG_SIZE,
  parameter int NUM_TAGS      = cpu_pkg::NUM_TAGS,
  parameter int ROB_SIZE      = cpu_pkg::ROB_SIZE,
  parameter int NUM_TAGS_LOG2 = $clog2(NUM_TAGS),
  parameter int ROB_SIZE_LOG2 = $clog2(ROB_SIZE)
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   flush,
  input  logic [NUM_REQ-1:0]                     req_valid,
  input  logic [NUM_REQ-1:0][ALU_OP_W-1:0]       req_op,
  input  logic [NUM_REQ-1:0][REG_SIZE-1:0]       req_rs1,
  input  logic [NUM_REQ-1:0][REG_SIZE-1:0]       req_rs2,
  input  logic [NUM_REQ-1:0][NUM_TAGS_LOG2-1:0]  req_tag,
  input  logic [NUM_REQ-1:0][ROB_SIZE_LOG2-1:0]  req_rob,
  output logic [NUM_REQ-1:0]                     req_gnt,
  output logic [ALU_OP_W-1:0]                    fu_op,
  output logic [REG_SIZE-1:0]                    fu_rs1,
  output logic [REG_SIZE-1:0]                    fu_rs2,
  output logic [NUM_TAGS_LOG2-1:0]               fu_tag,
  output logic [ROB_SIZE_LOG2-1:0]               fu_rob,
  output logic                                   fu_valid,
  input  logic [REG_SIZE-1:0]                    fu_rd,
  input  logic [NUM_TAGS_LOG2-1:0]               fu_tag_out,
  input  logic [ROB_SIZE_LOG2-1:0]               fu_rob_out,
  input  logic                                   fu_valid_out,
  output logic                                   cdb_valid,
  output logic [REG_SIZE-1:0]                    cdb_data,
  output logic [NUM_TAGS_LOG2-1:0]               cdb_tag,
  output logic [ROB_SIZE_LOG2-1:0]               cdb_rob,
  input  logic                                   cdb_ready
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // Issue stage
  logic                     r_iss_valid;
  logic [ALU_OP_W-1:0]      r_iss_op;
  logic [REG_SIZE-1:0]      r_iss_rs1;
  logic [REG_SIZE-1:0]      r_iss_rs2;
  logic [NUM_TAGS_LOG2-1:0] r_iss_tag;
  logic [ROB_SIZE_LOG2-1:0] r_iss_rob;
  // Result stage
  logic                     r_res_valid;
  logic [REG_SIZE-1:0]      r_res_data;
  logic [NUM_TAGS_LOG2-1:0] r_res_tag;
  logic [ROB_SIZE_LOG2-1:0] r_res_rob;
  // Round-robin priority pointer
  logic [PTR_W-1:0]         r_ptr;

  logic                     w_res_load;
  logic                     w_gnt_en;
  logic [NUM_REQ-1:0]       w_gnt;
  logic                     w_any;
  logic [PTR_W-1:0]         w_idx;
  logic [PTR_W-1:0]         w_next_ptr;

  // The whole pipe moves only when the result slot is free or being drained;
  // grants are also suppressed by flush and while reset is asserted.
  assign w_res_load = !r_res_valid || cdb_ready;
  assign w_gnt_en   = w_res_load && !flush && rst;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .i_en       (w_gnt_en),
    .i_req      (req_valid),
    .i_ptr      (r_ptr),
    .o_gnt      (w_gnt),
    .o_any      (w_any),
    .o_idx      (w_idx),
    .o_next_ptr (w_next_ptr)
  );

  assign req_gnt   = w_gnt;
  assign fu_op     = r_iss_op;
  assign fu_rs1    = r_iss_rs1;
  assign fu_rs2    = r_iss_rs2;
  assign fu_tag    = r_iss_tag;
  assign fu_rob    = r_iss_rob;
  assign fu_valid  = r_iss_valid;
  assign cdb_valid = r_res_valid;
  assign cdb_data  = r_res_data;
  assign cdb_tag   = r_res_tag;
  assign cdb_rob   = r_res_rob;

  // Issue stage and pointer: load the granted op, or go empty when the pipe advances without a grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_iss_valid <= 1'b0;
      r_iss_op    <= '0;
      r_iss_rs1   <= '0;
      r_iss_rs2   <= '0;
      r_iss_tag   <= '0;
      r_iss_rob   <= '0;
      r_ptr       <= '0;
    end else if (flush) begin
      r_iss_valid <= 1'b0;
      r_iss_op    <= '0;
      r_iss_rs1   <= '0;
      r_iss_rs2   <= '0;
      r_iss_tag   <= '0;
      r_iss_rob   <= '0;
    end else if (w_res_load) begin
      if (w_any) begin
        r_iss_valid <= 1'b1;
        r_iss_op    <= req_op[w_idx];
        r_iss_rs1   <= req_rs1[w_idx];
        r_iss_rs2   <= req_rs2[w_idx];
        r_iss_tag   <= req_tag[w_idx];
        r_iss_rob   <= req_rob[w_idx];
        r_ptr       <= w_next_ptr;
      end else begin
        r_iss_valid <= 1'b0;
        r_iss_op    <= '0;
        r_iss_rs1   <= '0;
        r_iss_rs2   <= '0;
        r_iss_tag   <= '0;
        r_iss_rob   <= '0;
      end
    end
  end

  // Result stage: capture the ALU output; fields are zeroed whenever the slot is empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_tag   <= '0;
      r_res_rob   <= '0;
    end else if (flush) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_tag   <= '0;
      r_res_rob   <= '0;
    end else if (w_res_load) begin
      r_res_valid <= fu_valid_out;
      r_res_data  <= fu_valid_out ? fu_rd      : '0;
      r_res_tag   <= fu_valid_out ? fu_tag_out : '0;
      r_res_rob   <= fu_valid_out ? fu_rob_out : '0;
    end
  end

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Bench for alu_issue_arbiter: directed scenarios plus randomized traffic,
// checked against a two-slot transaction model with a reference ALU.
module tb_alu_issue_arbiter;
  import cpu_pkg::*;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TW = 6;
  localparam int RW = 6;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    flush;
  logic [N-1:0]            req_valid;
  logic [N-1:0][3:0]       req_op;
  logic [N-1:0][W-1:0]     req_rs1;
  logic [N-1:0][W-1:0]     req_rs2;
  logic [N-1:0][TW-1:0]    req_tag;
  logic [N-1:0][RW-1:0]    req_rob;
  logic [N-1:0]            req_gnt;
  logic [3:0]              fu_op;
  logic [W-1:0]            fu_rs1, fu_rs2, fu_rd;
  logic [TW-1:0]           fu_tag, fu_tag_out;
  logic [RW-1:0]           fu_rob, fu_rob_out;
  logic                    fu_valid, fu_valid_out;
  logic                    cdb_valid;
  logic [W-1:0]            cdb_data;
  logic [TW-1:0]           cdb_tag;
  logic [RW-1:0]           cdb_rob;
  logic                    cdb_ready;

  int n_vec = 0;
  int n_err = 0;

  // Model: slot 1 = op issued to ALU (result precomputed), slot 2 = result on CDB
  int          m_ptr;
  bit          mi_v;
  logic [W-1:0]  mi_d;
  logic [TW-1:0] mi_tag;
  logic [RW-1:0] mi_rob;
  bit          mr_v;
  logic [W-1:0]  mr_d;
  logic [TW-1:0] mr_tag;
  logic [RW-1:0] mr_rob;

  alu_issue_arbiter dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_op(req_op), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_tag(req_tag), .req_rob(req_rob), .req_gnt(req_gnt),
    .fu_op(fu_op), .fu_rs1(fu_rs1), .fu_rs2(fu_rs2), .fu_tag(fu_tag), .fu_rob(fu_rob),
    .fu_valid(fu_valid), .fu_rd(fu_rd), .fu_tag_out(fu_tag_out), .fu_rob_out(fu_rob_out),
    .fu_valid_out(fu_valid_out), .cdb_valid(cdb_valid), .cdb_data(cdb_data),
    .cdb_tag(cdb_tag), .cdb_rob(cdb_rob), .cdb_ready(cdb_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      4'd7:    return W'($signed(a) >>> b[4:0]);
      4'd8:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9:    return (a < b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Combinational ALU in the environment
  assign fu_rd        = ref_alu(fu_op, fu_rs1, fu_rs2);
  assign fu_tag_out   = fu_tag;
  assign fu_rob_out   = fu_rob;
  assign fu_valid_out = fu_valid;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; mi_v = 0; mr_v = 0;
    mi_d = '0; mi_tag = '0; mi_rob = '0; mr_d = '0; mr_tag = '0; mr_rob = '0;
  endtask

  task automatic rand_payload();
    for (int i = 0; i < N; i++) begin
      req_op[i]  = 4'($urandom_range(0, 9));
      req_rs1[i] = $urandom;
      req_rs2[i] = $urandom;
      req_tag[i] = TW'($urandom);
      req_rob[i] = RW'($urandom);
    end
  endtask

  function automatic int exp_grant();
    if (flush) return -1;
    if (mr_v && !cdb_ready) return -1;
    for (int i = 0; i < N; i++) begin
      if (req_valid[(m_ptr + i) % N]) return (m_ptr + i) % N;
    end
    return -1;
  endfunction

  // Check outputs against the model, cross one rising edge, update the model.
  task automatic tick();
    int g;
    logic [N-1:0] eg;
    #1;
    g  = exp_grant();
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    chk("gnt", 64'(req_gnt), 64'(eg));
    chk("cdb_valid", 64'(cdb_valid), 64'(mr_v));
    chk("cdb_data", 64'(cdb_data), mr_v ? 64'(mr_d) : 64'd0);
    chk("cdb_tag", 64'(cdb_tag), mr_v ? 64'(mr_tag) : 64'd0);
    chk("cdb_rob", 64'(cdb_rob), mr_v ? 64'(mr_rob) : 64'd0);
    chk("fu_valid", 64'(fu_valid), 64'(mi_v));
    if (mi_v) chk("fu_result", 64'(fu_rd), 64'(mi_d));
    @(posedge clk);
    if (flush) begin
      mi_v = 0; mr_v = 0;
    end else if (!mr_v || cdb_ready) begin
      mr_v = mi_v; mr_d = mi_d; mr_tag = mi_tag; mr_rob = mi_rob;
      if (g >= 0) begin
        mi_v   = 1;
        mi_d   = ref_alu(req_op[g], req_rs1[g], req_rs2[g]);
        mi_tag = req_tag[g];
        mi_rob = req_rob[g];
        m_ptr  = (g + 1) % N;
      end else begin
        mi_v = 0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int ord [5];
    int p;
    logic [W-1:0]  d0;
    logic [TW-1:0] t0;
    logic [RW-1:0] r0;
    logic [N-1:0]  oh;
    ord = '{0, 1, 2, 3, 0};

    rst = 1'b0; flush = 1'b0; cdb_ready = 1'b1; req_valid = 4'hF;
    rand_payload();
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt", 64'(req_gnt), 64'd0);
    chk("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("rst_fu_valid", 64'(fu_valid), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // All four requesting: grants 0,1,2,3,0 starting on the first edge
    for (int i = 0; i < 5; i++) begin
      #1;
      oh = 4'b0001;
      oh = oh << ord[i];
      chk("rr_order", 64'(req_gnt), 64'(oh));
      tick();
    end

    // Requester 2 alone: ADD 5+7 -> CDB two cycles after grant
    req_valid = 4'b0100;
    req_op[2] = 4'(ALU_ADD); req_rs1[2] = 32'd5; req_rs2[2] = 32'd7;
    req_tag[2] = 6'd9; req_rob[2] = 6'd3;
    #1;
    chk("single_gnt", 64'(req_gnt), 64'h4);
    tick();
    req_valid = 4'b0000;
    tick();
    chk("add_valid", 64'(cdb_valid), 64'd1);
    chk("add_data", 64'(cdb_data), 64'd12);
    chk("add_tag", 64'(cdb_tag), 64'd9);
    chk("add_rob", 64'(cdb_rob), 64'd3);
    tick();
    tick();

    // Requester 1, then 1 and 3: 3 next, then 1
    rand_payload();
    req_valid = 4'b0010;
    #1; chk("r24_first", 64'(req_gnt), 64'h2);
    tick();
    req_valid = 4'b1010;
    #1; chk("r24_second", 64'(req_gnt), 64'h8);
    tick();
    #1; chk("r24_third", 64'(req_gnt), 64'h2);
    tick();
    req_valid = 4'b0000;
    tick();
    tick();

    // Backpressure for three cycles with a result pending
    rand_payload();
    req_valid = 4'hF;
    tick();
    tick();
    cdb_ready = 1'b0;
    d0 = cdb_data; t0 = cdb_tag; r0 = cdb_rob;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_gnt", 64'(req_gnt), 64'd0);
      chk("stall_valid", 64'(cdb_valid), 64'd1);
      chk("stall_data", 64'(cdb_data), 64'(d0));
      chk("stall_tag", 64'(cdb_tag), 64'(t0));
      chk("stall_rob", 64'(cdb_rob), 64'(r0));
      tick();
    end
    cdb_ready = 1'b1;
    req_valid = 4'b0000;
    repeat (3) tick();

    // Flush with both stages valid
    rand_payload();
    req_valid = 4'hF;
    tick();
    tick();
    p = m_ptr;
    flush = 1'b1;
    #1; chk("flush_gnt", 64'(req_gnt), 64'd0);
    tick();
    flush = 1'b0;
    chk("flush_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("flush_fu_valid", 64'(fu_valid), 64'd0);
    #1;
    oh = 4'b0001;
    oh = oh << p;
    chk("flush_ptr", 64'(req_gnt), 64'(oh));
    tick();
    req_valid = 4'b0000;
    tick();
    tick();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      req_valid = N'($urandom);
      cdb_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      rand_payload();
      tick();
    end
    flush = 1'b0;

    // Asynchronous reset during a stall
    cdb_ready = 1'b1;
    req_valid = 4'hF;
    tick();
    tick();
    cdb_ready = 1'b0;
    tick();
    #2 rst = 1'b0;
    #1;
    chk("arst_gnt", 64'(req_gnt), 64'd0);
    chk("arst_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("arst_cdb_data", 64'(cdb_data), 64'd0);
    chk("arst_cdb_tag", 64'(cdb_tag), 64'd0);
    chk("arst_cdb_rob", 64'(cdb_rob), 64'd0);
    chk("arst_fu_valid", 64'(fu_valid), 64'd0);
    chk("arst_fu_rs1", 64'(fu_rs1), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    cdb_ready = 1'b1;
    #1; chk("post_rst_gnt", 64'(req_gnt), 64'h1);
    tick();
    tick();
    req_valid = 4'b0000;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
